// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and the default datapath width.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_negate #(
   parameter int N = 32
) (
   input  logic         neg,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with hi/lo result
// registers, signed/unsigned variants and direct hi/lo writes while idle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // product upper half / partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;     // multiplier being shifted out / quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   op_e              op_in;
   logic             in_signed, in_div, is_div_q;
   logic [WIDTH-1:0] mag_a, mag_b;

   logic [WIDTH:0]          mul_sum;
   logic [2*WIDTH-1:0]      mul_prod, prod_fix;
   logic [WIDTH:0]          div_shift;
   logic signed [WIDTH:0]   div_trial;
   logic [WIDTH-1:0]        div_rem_nxt, div_quo_nxt, quo_fix, rem_fix;

   assign op_in     = op_e'(op);
   assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
   assign in_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
   assign is_div_q  = (op_q  == OP_DIV)  || (op_q  == OP_DIVU);

   muldiv_negate #(.N(WIDTH)) u_abs_a (
      .neg (in_signed & src_a[WIDTH-1]),
      .din (src_a),
      .dout(mag_a)
   );

   muldiv_negate #(.N(WIDTH)) u_abs_b (
      .neg (in_signed & src_b[WIDTH-1]),
      .din (src_b),
      .dout(mag_b)
   );

   // Shift-add step: the carry out of the add becomes the top product bit
   assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_prod = {mul_sum, quo_q[WIDTH-1:1]};

   // Restoring step: remainder stays below the divisor, so the trial sign
   // bit alone decides whether the subtraction is kept
   assign div_shift   = {rem_q, quo_q[WIDTH-1]};
   assign div_trial   = $signed(div_shift) - $signed({1'b0, opnd_q});
   assign div_rem_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
   assign div_quo_nxt = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};

   muldiv_negate #(.N(2*WIDTH)) u_fix_prod (
      .neg (neg_res_q),
      .din (mul_prod),
      .dout(prod_fix)
   );

   muldiv_negate #(.N(WIDTH)) u_fix_quo (
      .neg (neg_res_q),
      .din (div_quo_nxt),
      .dout(quo_fix)
   );

   muldiv_negate #(.N(WIDTH)) u_fix_rem (
      .neg (neg_rem_q),
      .din (div_rem_nxt),
      .dout(rem_fix)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CALC;
               op_d      = op_in;
               cnt_d     = '0;
               rem_d     = '0;
               quo_d     = in_div ? mag_a : mag_b;
               opnd_d    = in_div ? mag_b : mag_a;
               neg_res_d = in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
               neg_rem_d = in_signed & src_a[WIDTH-1];
               dbz_d     = in_div && (src_b == '0);
            end else begin
               if (mthi) hi_d = src_a;
               if (mtlo) lo_d = src_a;
            end
         end
         CALC: begin
            if (dbz_q) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (is_div_q) begin
                  rem_d = div_rem_nxt;
                  quo_d = div_quo_nxt;
               end else begin
                  rem_d = mul_sum[WIDTH:1];
                  quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
               end
               if (cnt_q == 6'(WIDTH - 1)) begin
                  state_d = DONE;
                  if (is_div_q) begin
                     hi_d = rem_fix;
                     lo_d = quo_fix;
                  end else begin
                     hi_d = prod_fix[2*WIDTH-1:WIDTH];
                     lo_d = prod_fix[WIDTH-1:0];
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= OP_MULT;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         opnd_q    <= opnd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign div_by_zero = (state_q == DONE) && dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   int          r_cyc;
   int          r_busy;
   logic [31:0] r_hi, r_lo;
   logic        r_dbz;
   logic        r_done_after;
   logic        saw_done;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .mthi       (mthi),
      .mtlo       (mtlo),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait for done; optionally hammer start/mtlo
   // while busy. Leaves the unit back in IDLE on return.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      r_cyc = 1;
      r_busy = 0;
      while (!done && r_cyc < 40) begin
         if (busy) begin
            r_busy++;
            if (disturb) begin
               start = 1'b1; mtlo = 1'b1; op = 2'b11; src_a = 32'hDEAD_BEEF;
            end
         end
         @(posedge clk); #1;
         r_cyc++;
      end
      start = 1'b0; mtlo = 1'b0;
      r_hi = hi; r_lo = lo; r_dbz = div_by_zero;
      @(posedge clk); #1;
      r_done_after = done;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      mthi = 1'b0; mtlo = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz",  32'(div_by_zero), 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // MULTU max x max, accepted on first edge after reset release
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_cyc",  32'(r_cyc), 32'd33);
      chk("multu_busy", 32'(r_busy), 32'd32);
      chk("multu_hi", r_hi, 32'hFFFF_FFFE);
      chk("multu_lo", r_lo, 32'h0000_0001);
      chk("multu_dbz", 32'(r_dbz), 32'd0);
      chk("multu_done_pulse", 32'(r_done_after), 32'd0);
      chk("multu_hold_hi", hi, 32'hFFFF_FFFE);

      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
      chk("mult_hi", r_hi, 32'hFFFF_FFFF);
      chk("mult_lo", r_lo, 32'hFFFF_FFF1);

      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      chk("div_lo", r_lo, 32'hFFFF_FFFD);
      chk("div_hi", r_hi, 32'hFFFF_FFFF);

      run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0);
      chk("divu_lo", r_lo, 32'h0000_0003);
      chk("divu_hi", r_hi, 32'h0000_0001);
      chk("divu_cyc", 32'(r_cyc), 32'd33);

      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf_lo", r_lo, 32'h8000_0000);
      chk("div_ovf_hi", r_hi, 32'h0000_0000);

      // mthi and mtlo together
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; src_a = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      chk("mthilo_hi", hi, 32'hA5A5_A5A5);
      chk("mthilo_lo", lo, 32'hA5A5_A5A5);

      @(negedge clk);
      mthi = 1'b1; src_a = 32'h1234_5678;
      @(posedge clk); #1;
      mthi = 1'b0;
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_lo_kept", lo, 32'hA5A5_A5A5);

      // Divide by zero with mthi asserted alongside start: start wins
      @(negedge clk);
      mthi = 1'b1;
      run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
      mthi = 1'b0;
      chk("dbz_cyc", 32'(r_cyc), 32'd2);
      chk("dbz_flag", 32'(r_dbz), 32'd1);
      chk("dbz_hi", r_hi, 32'h1234_5678);
      chk("dbz_lo", r_lo, 32'hA5A5_A5A5);
      chk("dbz_flag_clear", 32'(div_by_zero), 32'd0);

      // start, mtlo and operand changes during CALC are ignored
      run_op(2'b01, 32'h0000_0006, 32'h0000_0007, 1'b1);
      chk("dist_cyc", 32'(r_cyc), 32'd33);
      chk("dist_lo", r_lo, 32'h0000_002A);
      chk("dist_hi", r_hi, 32'h0000_0000);
      chk("dist_lo_after", lo, 32'h0000_002A);
      chk("dist_busy_after", 32'(busy), 32'd0);

      // Reset in the middle of a MULT
      saw_done = 1'b0;
      @(negedge clk);
      op = 2'b00; src_a = 32'h0000_1234; src_b = 32'hFFFF_0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_hi", hi, 32'h0);
      chk("mid_rst_lo", lo, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      chk("mid_no_done", 32'(saw_done), 32'd0);

      run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 1'b0);
      chk("post_rst_cyc", 32'(r_cyc), 32'd33);
      chk("post_rst_lo", r_lo, 32'h0000_000C);
      chk("post_rst_hi", r_hi, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
